// File: rtl/com_delay_meas_pkg.sv
// Shared types and constants for the loopback latency meter.
package com_delay_meas_pkg;

   // Measurement sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_INJECT = 2'd1,
      ST_WAIT   = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   // Marker word injected onto the transmit path and searched for on receive.
   localparam logic [31:0] C_MARKER_DEFAULT = 32'hA5C3_5A3C;

   // Word driven while waiting for the marker, so payload cannot false-match.
   localparam logic [31:0] C_IDLE_WORD = 32'h0000_0000;

   // Width of every delay value (counter, results).
   localparam int C_DELAY_W = 11;

   // Saturated result reported on timeout.
   localparam logic [C_DELAY_W-1:0] C_DELAY_SAT = 11'h7FF;

endpackage

// File: rtl/com_delay_stats.sv
// Delay statistics: running sum, minimum and maximum over one measurement run.
// Results are published straight from the registers, so they change only when
// a sample is accepted, the run is cleared, or a timeout is flagged.
module com_delay_stats
   import com_delay_meas_pkg::*;
#(
   parameter int C_NUM_MEAS_LOG2 = 2
) (
   input  logic                 I_clk,
   input  logic                 I_rst,
   input  logic                 I_clear,
   input  logic                 I_sampleValid,
   input  logic [C_DELAY_W-1:0] I_sample,
   input  logic                 I_timeout,
   output logic [C_DELAY_W-1:0] O_avg,
   output logic [C_DELAY_W-1:0] O_min,
   output logic [C_DELAY_W-1:0] O_max,
   output logic                 O_timeout
);

   // Wide enough to hold 2^C_NUM_MEAS_LOG2 samples of the largest delay.
   localparam int ACC_W = C_DELAY_W + C_NUM_MEAS_LOG2;

   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [C_DELAY_W-1:0] min_q, min_d;
   logic [C_DELAY_W-1:0] max_q, max_d;
   logic                 to_q,  to_d;

   // Next-state: clear starts a fresh run, otherwise fold in the new sample.
   always_comb begin
      acc_d = acc_q;
      min_d = min_q;
      max_d = max_q;
      to_d  = to_q;
      if (I_clear) begin
         acc_d = '0;
         min_d = C_DELAY_SAT;
         max_d = '0;
         to_d  = 1'b0;
      end else begin
         if (I_sampleValid) begin
            acc_d = acc_q + ACC_W'(I_sample);
            if (I_sample < min_q) begin
               min_d = I_sample;
            end
            if (I_sample > max_q) begin
               max_d = I_sample;
            end
         end
         if (I_timeout) begin
            to_d = 1'b1;
         end
      end
   end

   // Statistics registers; reset drives every published result to zero.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         acc_q <= '0;
         min_q <= '0;
         max_q <= '0;
         to_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         min_q <= min_d;
         max_q <= max_d;
         to_q  <= to_d;
      end
   end

   // Average is the truncated sum divided by the power-of-two sample count.
   assign O_avg     = to_q ? C_DELAY_SAT : acc_q[ACC_W-1 -: C_DELAY_W];
   assign O_min     = to_q ? C_DELAY_SAT : min_q;
   assign O_max     = to_q ? C_DELAY_SAT : max_q;
   assign O_timeout = to_q;

endmodule

// File: rtl/com_delay_meas.sv
// Loopback latency meter: passes transmit data through in idle, and on start
// injects a marker, counts clocks until it returns, repeats, and reports
// average / minimum / maximum delay.
module com_delay_meas
   import com_delay_meas_pkg::*;
#(
   parameter logic [31:0]          C_MARKER        = C_MARKER_DEFAULT,
   parameter logic [C_DELAY_W-1:0] C_MAX_DELAY     = 11'd1024,
   parameter int                   C_NUM_MEAS_LOG2 = 2
) (
   input  logic                 I_clk,
   input  logic                 I_rst,
   input  logic                 I_start,
   input  logic [31:0]          I_srcData,
   output logic [31:0]          O_dstData,
   input  logic [31:0]          I_rxData,
   output logic                 O_busy,
   output logic                 O_done,
   output logic                 O_timeout,
   output logic [C_DELAY_W-1:0] O_delay,
   output logic [C_DELAY_W-1:0] O_delayMin,
   output logic [C_DELAY_W-1:0] O_delayMax
);

   // One spare bit keeps the index non-empty when only one measurement is run.
   localparam int                   IDX_W     = C_NUM_MEAS_LOG2 + 1;
   localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'((1 << C_NUM_MEAS_LOG2) - 1);
   localparam logic [C_DELAY_W-1:0] CNT_LIMIT = C_MAX_DELAY - 11'd1;

   state_t               state_q, state_d;
   logic [C_DELAY_W-1:0] cnt_q, cnt_d;
   logic [C_DELAY_W-1:0] cnt_cur;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [31:0]          pass_q;
   logic                 rx_match;
   logic                 stat_clear;
   logic                 stat_valid;
   logic                 stat_timeout;

   // The marker cycle itself counts as delay 0, so a combinational loop reads 0.
   assign cnt_cur  = (state_q == ST_INJECT) ? '0 : cnt_q;
   assign rx_match = (I_rxData == C_MARKER);

   // State, delay counter, measurement index and the passthrough register.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         pass_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pass_q  <= I_srcData;
      end
   end

   // Sequencer: accept start, detect marker or timeout, step through the run.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      stat_clear   = 1'b0;
      stat_valid   = 1'b0;
      stat_timeout = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (I_start) begin
               state_d    = ST_INJECT;
               idx_d      = '0;
               stat_clear = 1'b1;
            end
         end
         ST_INJECT, ST_WAIT: begin
            if (rx_match) begin
               stat_valid = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = ST_REPORT;
               end else begin
                  state_d = ST_INJECT;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end else if (cnt_cur == CNT_LIMIT) begin
               // Counter would reach the limit next cycle: give up.
               state_d      = ST_REPORT;
               stat_timeout = 1'b1;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = cnt_cur + 11'd1;
            end
         end
         ST_REPORT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Transmit mux: marker on inject, idle word while waiting, payload otherwise.
   always_comb begin
      O_dstData = pass_q;
      case (state_q)
         ST_INJECT: O_dstData = C_MARKER;
         ST_WAIT:   O_dstData = C_IDLE_WORD;
         default:   O_dstData = pass_q;
      endcase
   end

   assign O_busy = (state_q == ST_INJECT) || (state_q == ST_WAIT);
   assign O_done = (state_q == ST_REPORT);

   com_delay_stats #(
      .C_NUM_MEAS_LOG2 (C_NUM_MEAS_LOG2)
   ) u_stats (
      .I_clk         (I_clk),
      .I_rst         (I_rst),
      .I_clear       (stat_clear),
      .I_sampleValid (stat_valid),
      .I_sample      (cnt_cur),
      .I_timeout     (stat_timeout),
      .O_avg         (O_delay),
      .O_min         (O_delayMin),
      .O_max         (O_delayMax),
      .O_timeout     (O_timeout)
   );

endmodule

// File: tb/tb_com_delay_meas.sv
// Bench for the loopback latency meter: a loopback emulator returns each
// marker after a chosen delay, a reference model predicts each report, and a
// monitor compares reports as the DUT raises O_done.
module tb_com_delay_meas;
   import com_delay_meas_pkg::*;

   localparam logic [31:0] MARK = 32'hA5C3_5A3C;
   localparam int MAXD = 1024;
   localparam int LOG2N = 2;
   localparam int NMEAS = 4;

   typedef struct {
      int cyc;
      int dly;
      int mn;
      int mx;
      int to;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] src = '0;
   logic [31:0] rx = '0;
   logic [31:0] O_dstData;
   logic        O_busy, O_done, O_timeout;
   logic [10:0] O_delay, O_delayMin, O_delayMax;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   int   dly_q[$];
   int   ret_q[$];
   int   ret_tmp[$];
   bit   force_rx = 1'b0;
   int   lb_d;
   bit   lb_hit;
   logic [31:0] lb_noise;
   exp_t mon_e;

   com_delay_meas #(
      .C_MARKER        (MARK),
      .C_MAX_DELAY     (11'(MAXD)),
      .C_NUM_MEAS_LOG2 (LOG2N)
   ) dut (
      .I_clk      (clk),
      .I_rst      (rst),
      .I_start    (start),
      .I_srcData  (src),
      .O_dstData  (O_dstData),
      .I_rxData   (rx),
      .O_busy     (O_busy),
      .O_done     (O_done),
      .O_timeout  (O_timeout),
      .O_delay    (O_delay),
      .O_delayMin (O_delayMin),
      .O_delayMax (O_delayMax)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Loopback emulator: each marker seen on the transmit side while busy is
   // returned after the next delay from dly_q (negative = never returns).
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (O_busy === 1'b1 && O_dstData === MARK && dly_q.size() > 0) begin
            lb_d = dly_q.pop_front();
            if (lb_d >= 0) ret_q.push_back(cyc + lb_d);
         end
         lb_hit = force_rx;
         ret_tmp = {};
         foreach (ret_q[i]) begin
            if (ret_q[i] == cyc) lb_hit = 1'b1;
            if (ret_q[i] > cyc) ret_tmp.push_back(ret_q[i]);
         end
         ret_q = ret_tmp;
         lb_noise = $urandom;
         if (lb_noise == MARK) lb_noise = 32'h0;
         rx = lb_hit ? MARK : lb_noise;
      end
   end

   // Monitor: every O_done pulse must match the oldest predicted report.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (O_done === 1'b1) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_done: got O_done=1 required 0 (cycle %0d)", cyc);
            end else begin
               mon_e = sb.pop_front();
               chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
               chk("delay", 64'(O_delay), 64'(mon_e.dly));
               chk("delay_min", 64'(O_delayMin), 64'(mon_e.mn));
               chk("delay_max", 64'(O_delayMax), 64'(mon_e.mx));
               chk("timeout", 64'(O_timeout), 64'(mon_e.to));
               $display("report cycle %0d: delay=%0d min=%0d max=%0d timeout=%0d",
                        cyc, O_delay, O_delayMin, O_delayMax, O_timeout);
            end
         end
      end
   end

   // One measurement run; model predicts the report from the chosen delays.
   task automatic run(input int d0, input int d1, input int d2, input int d3, input bit poke);
      int   d[4];
      exp_t e;
      int   p, sum, budget;
      d = '{d0, d1, d2, d3};
      tick();
      start = 1'b1;
      p = cyc + 1;
      sum = 0;
      e.mn = 2047;
      e.mx = 0;
      e.to = 0;
      for (int k = 0; k < NMEAS; k++) begin
         dly_q.push_back(d[k]);
         if (d[k] < 0 || d[k] >= MAXD) begin
            p += MAXD;
            e.to = 1;
            break;
         end
         p += d[k] + 1;
         sum += d[k];
         if (d[k] < e.mn) e.mn = d[k];
         if (d[k] > e.mx) e.mx = d[k];
      end
      e.cyc = p;
      if (e.to != 0) begin
         e.dly = 2047;
         e.mn = 2047;
         e.mx = 2047;
      end else begin
         e.dly = sum / NMEAS;
      end
      sb.push_back(e);
      $display("run start cycle %0d: delays %0d %0d %0d %0d", cyc, d0, d1, d2, d3);
      tick();
      start = 1'b0;
      if (poke) begin
         repeat (3) tick();
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      budget = e.cyc - cyc + 20;
      while (sb.size() > 0 && budget > 0) begin
         src = $urandom;
         tick();
         budget--;
      end
      if (sb.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL done_wait: got no O_done required one by cycle %0d", e.cyc);
         sb.delete();
         dly_q.delete();
      end
      repeat (3) tick();
      chk("hold_delay", 64'(O_delay), 64'(e.dly));
      chk("hold_min", 64'(O_delayMin), 64'(e.mn));
      chk("hold_max", 64'(O_delayMax), 64'(e.mx));
      chk("hold_timeout", 64'(O_timeout), 64'(e.to));
      chk("idle_busy", 64'(O_busy), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_dst"}, 64'(O_dstData), 64'd0);
      chk({tag, "_busy"}, 64'(O_busy), 64'd0);
      chk({tag, "_done"}, 64'(O_done), 64'd0);
      chk({tag, "_timeout"}, 64'(O_timeout), 64'd0);
      chk({tag, "_delay"}, 64'(O_delay), 64'd0);
      chk({tag, "_min"}, 64'(O_delayMin), 64'd0);
      chk({tag, "_max"}, 64'(O_delayMax), 64'd0);
   endtask

   initial begin
      logic [31:0] v;
      int rd[4];

      // Reset state
      rst = 1'b1;
      src = 32'hDEAD_BEEF;
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0;

      // Passthrough, one register stage
      for (int i = 0; i < 8; i++) begin
         v = (i == 0) ? 32'h1234_5678 : $urandom;
         src = v;
         tick();
         chk("passthrough", 64'(O_dstData), 64'(v));
         $display("passthrough 0x%08h", O_dstData);
      end

      // Directed runs (first one also pokes start while busy)
      run(10, 10, 10, 10, 1'b1);
      run(0, 0, 0, 0, 1'b0);
      run(3, 5, 7, 9, 1'b0);
      run(-1, -1, -1, -1, 1'b0);
      run(1023, 2, 2, 2, 1'b0);
      run(4, 1024, 0, 0, 1'b0);

      // Marker in payload and on receive while idle: no effect
      src = MARK;
      force_rx = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_marker_busy", 64'(O_busy), 64'd0);
         if (i > 0) chk("idle_marker_dst", 64'(O_dstData), 64'(MARK));
      end
      force_rx = 1'b0;
      tick();

      // Reset in the middle of WAIT; the late marker must be ignored
      tick();
      start = 1'b1;
      dly_q.push_back(50);
      tick();
      start = 1'b0;
      repeat (20) tick();
      chk("pre_reset_busy", 64'(O_busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dly_q.delete();
      chk_all_zero("mid_reset");
      for (int i = 0; i < 40; i++) begin
         v = $urandom;
         src = v;
         tick();
         chk("post_reset_pass", 64'(O_dstData), 64'(v));
         chk("post_reset_busy", 64'(O_busy), 64'd0);
      end

      // Randomized runs
      for (int r = 0; r < 30; r++) begin
         for (int k = 0; k < NMEAS; k++) rd[k] = $urandom_range(0, 40);
         if ($urandom_range(0, 9) == 0) rd[$urandom_range(0, 3)] = -1;
         run(rd[0], rd[1], rd[2], rd[3], 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 5)) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/com_delay_meas.md
# com_delay_meas

Loopback latency meter for the 32-bit sample path. In idle it passes `I_srcData` to `O_dstData` with one register stage. On `I_start` it injects a marker word onto the transmit path and counts clocks until the marker returns on `I_rxData`. It repeats this 2^C_NUM_MEAS_LOG2 times and reports the average, minimum and maximum delay. The result is used to set delay-line depths that align parallel paths in the testbed datapath.

## Interface
- `C_MARKER`, 32'hA5C3_5A3C: marker word injected and detected.
- `C_MAX_DELAY`, 11'd1024: timeout limit in clocks; legal range is 2..2047.
- `C_NUM_MEAS_LOG2`, 2: log2 of the number of measurements averaged; legal range is 0..4.
- `I_clk`, in, 1: the single clock.
- `I_rst`, in, 1: synchronous, active-high reset.
- `I_start`, in, 1: starts a measurement run; sampled only in IDLE.
- `I_srcData`, in, 32: normal transmit data.
- `O_dstData`, out, 32: registered transmit data, or the marker/idle word during a run.
- `I_rxData`, in, 32: returned loopback data.
- `O_busy`, out, 1: high in INJECT and WAIT.
- `O_done`, out, 1: one-cycle pulse in REPORT.
- `O_timeout`, out, 1: held until the next accepted `I_start`.
- `O_delay`, out, 11: average delay in clocks.
- `O_delayMin`, out, 11: minimum measured delay.
- `O_delayMax`, out, 11: maximum measured delay.

## Operation
- **States:** IDLE, INJECT, WAIT, REPORT.
- **IDLE:** `O_dstData <= I_srcData`.
  - `I_start=1` → INJECT.
  - Clears `O_timeout`, the accumulator and the measurement index.
  - Sets min to 0x7FF and max to 0.
- **INJECT (one cycle):** `O_dstData = C_MARKER`; counter = 0.
  - `I_rxData` is compared in this same cycle, so a combinational loop reads delay 0.
  - No match → WAIT.
- **WAIT:** `O_dstData = 32'h0` (idle word, which prevents a payload false match); counter increments each cycle.
- **On match** (`I_rxData == C_MARKER`, in INJECT or WAIT):
  - Add the counter to the accumulator and update min/max.
  - If this was the last measurement → REPORT; otherwise → INJECT on the next cycle.
- **Timeout:** no match while the counter is in 0..C_MAX_DELAY-1.
  - In the cycle the counter would reach C_MAX_DELAY → REPORT.
  - Set `O_timeout=1`; force `O_delay`, `O_delayMin` and `O_delayMax` to 0x7FF.
- **REPORT:**
  - `O_done=1`.
  - Result outputs update in the cycle REPORT is entered.
  - Next state is IDLE.
- **Arithmetic:**
  - Accumulator width is 11+C_NUM_MEAS_LOG2 bits and never overflows.
  - Average = accumulator >> C_NUM_MEAS_LOG2, truncated.
- **Ignored inputs:**
  - `I_start` outside IDLE.
  - A marker arriving in IDLE or REPORT.
- **Reset:**
  - `I_rst` at any point returns to IDLE on the next edge.
  - All outputs go to 0, including `O_dstData`.
  - Any marker still in flight is ignored.

## Timing
- Passthrough latency: 1 clock.
- Start accepted at cycle t → marker on `O_dstData` at t+1.
- A match at counter k means delay k: the marker was on `O_dstData` k cycles earlier.
- Back-to-back measurements: the next marker is driven the cycle after a match. Run time is N·(D+1) cycles; `O_done` is high at t + N·(D+1) + 1.
- Results hold stable from REPORT until the next accepted start.

## Structure
- **Package `com_delay_meas_pkg`:** state enum, default marker constant, delay width constant (11), saturation value 0x7FF.
- **Sub-module `com_delay_stats`:** accumulator plus min/max registers.
  - Inputs: clear, sample-valid, 11-bit sample, timeout.
  - Outputs: avg, min, max.
- The top level holds the FSM, counter, comparator and output mux.

## Test plan
- **Passthrough:** IDLE, `I_srcData=32'h12345678` at cycle t → `O_dstData=32'h12345678` at t+1.
- **Registered loopback, D=10, N=4:** start at cycle 0 → markers at 1, 12, 23, 34; `O_done` at 45; delay, min and max all 10; `O_timeout=0`.
- **Combinational loopback (D=0):** delay, min and max all 0; `O_done` at cycle 5.
- **Varying loop delay** 3, 5, 7, 9 per measurement → `O_delay=6`, `O_delayMin=3`, `O_delayMax=9`.
- **Broken loop** (`I_rxData=0`), C_MAX_DELAY=1024 → `O_done` and `O_timeout=1` with all results 0x7FF; payload containing `C_MARKER` while in IDLE → no effect.
- **Start while busy** ignored; `I_rst` pulsed mid-WAIT → IDLE next cycle, all outputs 0, passthrough resumes, late marker ignored.
